// File: rtl/axi_pkg.sv
// Shared AXI constants and engine state encoding for the burst read/write engines.
package axi_pkg;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2,
    ST_DONE = 2'd3
  } engine_state_e;

  function automatic logic [2:0] axi_size_for(input int data_width);
    return 3'($clog2(data_width / 8));
  endfunction

endpackage

// File: rtl/axi_burst_splitter.sv
// Beat count of the next burst: min(remaining words, max burst length, words left in the 4 KB page).
module axi_burst_splitter #(
  parameter int DataWidth       = 32,
  parameter int BufferAddrWidth = 8,
  parameter int AXIMaxBurstLen  = 16
) (
  input  logic [11:0]                page_offset,
  input  logic [BufferAddrWidth-1:0] remaining,
  output logic [8:0]                 beats
);

  localparam int ByteShift = $clog2(DataWidth / 8);
  localparam int CW = (BufferAddrWidth > 13) ? BufferAddrWidth : 13;
  localparam logic [12:0] MaxBurst = 13'(AXIMaxBurstLen);

  logic [12:0]   words_to_4k_s;
  logic [12:0]   cap_s;
  logic [CW-1:0] rem_s;

  // Clamp the remaining word count to both the burst limit and the page boundary
  always_comb begin
    words_to_4k_s = (13'h1000 - {1'b0, page_offset}) >> ByteShift;
    cap_s = (words_to_4k_s < MaxBurst) ? words_to_4k_s : MaxBurst;
    rem_s = CW'(remaining);
    if (rem_s < CW'(cap_s)) begin
      beats = rem_s[8:0];
    end else begin
      beats = cap_s[8:0];
    end
  end

endmodule

// File: rtl/axi_burst_read_engine.sv
// Reads a linear AXI region in 4 KB-safe INCR bursts, one outstanding at a time,
// and streams each beat into a word-addressed buffer.
module axi_burst_read_engine
  import axi_pkg::*;
#(
  parameter int AXIAddrWidth    = 32,
  parameter int DataWidth       = 32,
  parameter int BufferAddrWidth = 8,
  parameter int AXIMaxBurstLen  = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start_valid,
  output logic                       start_ready,
  input  logic [BufferAddrWidth-1:0] data_ptr,
  input  logic [BufferAddrWidth-1:0] data_size,
  input  logic [AXIAddrWidth-1:0]    axi_offset,
  output logic                       done_valid,
  input  logic                       done_ready,
  output logic                       done_err,
  output logic [BufferAddrWidth-1:0] buffer_addr,
  output logic [DataWidth-1:0]       buffer_data,
  output logic                       buffer_ce,
  output logic                       buffer_we,
  output logic [AXIAddrWidth-1:0]    araddr,
  output logic [7:0]                 arlen,
  output logic [2:0]                 arsize,
  output logic [1:0]                 arburst,
  output logic                       arvalid,
  input  logic                       arready,
  input  logic [DataWidth-1:0]       rdata,
  input  logic [1:0]                 rresp,
  input  logic                       rlast,
  input  logic                       rvalid,
  output logic                       rready
);

  localparam int ByteShift = $clog2(DataWidth / 8);
  localparam logic [AXIAddrWidth-1:0] AlignMask =
    ~AXIAddrWidth'((64'd1 << ByteShift) - 64'd1);

  engine_state_e               state_r;
  logic [BufferAddrWidth-1:0]  ptr_r;
  logic [BufferAddrWidth-1:0]  remaining_r;
  logic [AXIAddrWidth-1:0]     next_addr_r;
  logic [8:0]                  beats_left_r;

  logic [AXIAddrWidth-1:0]     split_addr_s;
  logic [BufferAddrWidth-1:0]  split_rem_s;
  logic [8:0]                  beats_s;
  logic [7:0]                  arlen_s;
  logic [AXIAddrWidth-1:0]     burst_bytes_s;
  logic [BufferAddrWidth-1:0]  rem_dec_s;
  logic                        beat_s;
  logic                        last_beat_s;
  logic                        beat_err_s;

  assign arsize  = axi_size_for(DataWidth);
  assign arburst = AXI_BURST_INCR;

  // The first burst is sized from the request itself, later ones from the running state
  always_comb begin
    if (state_r == ST_IDLE) begin
      split_addr_s = axi_offset & AlignMask;
      split_rem_s  = data_size;
    end else begin
      split_addr_s = next_addr_r;
      split_rem_s  = remaining_r;
    end
  end

  axi_burst_splitter #(
    .DataWidth      (DataWidth),
    .BufferAddrWidth(BufferAddrWidth),
    .AXIMaxBurstLen (AXIMaxBurstLen)
  ) u_splitter (
    .page_offset(split_addr_s[11:0]),
    .remaining  (split_rem_s),
    .beats      (beats_s)
  );

  assign arlen_s       = 8'(beats_s - 9'd1);
  assign burst_bytes_s = AXIAddrWidth'(beats_s) << ByteShift;
  assign rem_dec_s     = BufferAddrWidth'(beats_s);

  // Buffer writes happen in the very cycle the beat is accepted
  assign beat_s      = rvalid && rready;
  assign last_beat_s = (beats_left_r == 9'd1);
  assign beat_err_s  = (rresp != AXI_RESP_OKAY) || (rlast != last_beat_s);
  assign buffer_ce   = beat_s;
  assign buffer_we   = beat_s;
  assign buffer_addr = beat_s ? ptr_r : {BufferAddrWidth{1'b0}};
  assign buffer_data = beat_s ? rdata : {DataWidth{1'b0}};

  // Transfer sequencing: request latch, burst issue, beat counting, completion handshake
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      start_ready  <= 1'b1;
      done_valid   <= 1'b0;
      done_err     <= 1'b0;
      arvalid      <= 1'b0;
      araddr       <= {AXIAddrWidth{1'b0}};
      arlen        <= 8'd0;
      rready       <= 1'b0;
      ptr_r        <= {BufferAddrWidth{1'b0}};
      remaining_r  <= {BufferAddrWidth{1'b0}};
      next_addr_r  <= {AXIAddrWidth{1'b0}};
      beats_left_r <= 9'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_valid) begin
            start_ready <= 1'b0;
            ptr_r       <= data_ptr;
            done_err    <= 1'b0;
            if (data_size == {BufferAddrWidth{1'b0}}) begin
              remaining_r <= {BufferAddrWidth{1'b0}};
              next_addr_r <= split_addr_s;
              done_valid  <= 1'b1;
              state_r     <= ST_DONE;
            end else begin
              araddr      <= split_addr_s;
              arlen       <= arlen_s;
              arvalid     <= 1'b1;
              next_addr_r <= split_addr_s + burst_bytes_s;
              remaining_r <= split_rem_s - rem_dec_s;
              state_r     <= ST_AR;
            end
          end
        end
        ST_AR: begin
          if (arready) begin
            arvalid      <= 1'b0;
            rready       <= 1'b1;
            beats_left_r <= {1'b0, arlen} + 9'd1;
            state_r      <= ST_R;
          end
        end
        ST_R: begin
          if (beat_s) begin
            ptr_r        <= ptr_r + {{(BufferAddrWidth-1){1'b0}}, 1'b1};
            beats_left_r <= beats_left_r - 9'd1;
            if (beat_err_s) begin
              done_err <= 1'b1;
            end
            if (last_beat_s) begin
              rready <= 1'b0;
              if (remaining_r != {BufferAddrWidth{1'b0}}) begin
                araddr      <= split_addr_s;
                arlen       <= arlen_s;
                arvalid     <= 1'b1;
                next_addr_r <= split_addr_s + burst_bytes_s;
                remaining_r <= split_rem_s - rem_dec_s;
                state_r     <= ST_AR;
              end else begin
                done_valid <= 1'b1;
                state_r    <= ST_DONE;
              end
            end
          end
        end
        ST_DONE: begin
          if (done_ready) begin
            done_valid  <= 1'b0;
            start_ready <= 1'b1;
            state_r     <= ST_IDLE;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          start_ready <= 1'b1;
          done_valid  <= 1'b0;
          arvalid     <= 1'b0;
          rready      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_burst_read_engine.sv
// Randomized bench: AXI slave model with stalls, reference burst plan and buffer image.
module tb_axi_burst_read_engine;

  logic        clk;
  logic        reset_n;
  logic        start_valid;
  logic        start_ready;
  logic [7:0]  data_ptr;
  logic [7:0]  data_size;
  logic [31:0] axi_offset;
  logic        done_valid;
  logic        done_ready;
  logic        done_err;
  logic [7:0]  buffer_addr;
  logic [31:0] buffer_data;
  logic        buffer_ce;
  logic        buffer_we;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  axi_burst_read_engine dut (
    .clk(clk), .reset_n(reset_n),
    .start_valid(start_valid), .start_ready(start_ready),
    .data_ptr(data_ptr), .data_size(data_size), .axi_offset(axi_offset),
    .done_valid(done_valid), .done_ready(done_ready), .done_err(done_err),
    .buffer_addr(buffer_addr), .buffer_data(buffer_data),
    .buffer_ce(buffer_ce), .buffer_we(buffer_we),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          n_checks = 0;
  int          n_pass = 0;
  int          stall_pct = 0;
  int          err_beat = -1;
  int          ar_seen = 0;
  int          global_beat = 0;
  logic [31:0] mem [0:4095];
  logic [31:0] tb_buf [0:255];
  logic [31:0] exp_buf [0:255];
  logic [31:0] snap [0:255];
  logic [39:0] exp_ar [$];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
  endtask

  // Reference: burst list from min(remaining, 16, words to 4 KB page end), buffer image with wrap
  task automatic plan(input int ptr, input int size, input int offset);
    int addr;
    int rem;
    int b;
    addr = offset & ~3;
    rem = size;
    while (rem > 0) begin
      b = rem;
      if (b > 16) b = 16;
      if (b > (4096 - (addr % 4096)) / 4) b = (4096 - (addr % 4096)) / 4;
      exp_ar.push_back({32'(addr), 8'(b - 1)});
      addr += b * 4;
      rem -= b;
    end
    for (int i = 0; i < size; i++)
      exp_buf[(ptr + i) % 256] = mem[((offset >> 2) + i) % 4096];
  endtask

  // AXI slave: random arready/rvalid stalls, checks each AR, captures buffer writes
  initial begin
    int cur_word;
    int beats_left;
    bit busy;
    busy = 1'b0; cur_word = 0; beats_left = 0;
    arready = 1'b0; rvalid = 1'b0; rdata = 32'd0; rresp = 2'b00; rlast = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        arready = 1'b0; rvalid = 1'b0; busy = 1'b0;
        continue;
      end
      arready = !busy && ($urandom_range(99) >= stall_pct);
      if (busy && ($urandom_range(99) >= stall_pct)) begin
        rvalid = 1'b1;
        rdata  = mem[cur_word & 4095];
        rresp  = (global_beat == err_beat) ? 2'b10 : 2'b00;
        rlast  = (beats_left == 1);
      end else begin
        rvalid = 1'b0; rdata = $urandom; rresp = 2'b00; rlast = 1'b0;
      end
      #1;
      if (start_valid && start_ready) global_beat = 0;
      if (arvalid) ar_seen++;
      if (rvalid) check_eq("ce_we", {buffer_ce, buffer_we}, {2{rready}});
      if (buffer_ce && buffer_we) tb_buf[buffer_addr] = buffer_data;
      if (arvalid && arready) begin
        check_eq("ar_expected", exp_ar.size() > 0, 1'b1);
        if (exp_ar.size() > 0) check_eq("ar_addr_len", {araddr, arlen}, exp_ar.pop_front());
        check_eq("ar_size_burst", {arsize, arburst}, {3'd2, 2'b01});
        busy = 1'b1;
        cur_word = int'(araddr >> 2);
        beats_left = int'(arlen) + 1;
      end
      if (rvalid && rready) begin
        cur_word++;
        beats_left--;
        global_beat++;
        if (beats_left == 0) busy = 1'b0;
      end
    end
  end

  task automatic run_xfer(input int ptr, input int size, input int offset,
                          input int stall, input int done_delay, input int eb);
    int seen0;
    int cyc;
    int nbad;
    logic exp_err;
    stall_pct = stall;
    err_beat = eb;
    plan(ptr, size, offset);
    exp_err = (eb >= 0) && (eb < size);
    @(negedge clk);
    start_valid = 1'b1; data_ptr = 8'(ptr); data_size = 8'(size); axi_offset = 32'(offset);
    #2;
    seen0 = ar_seen;
    check_eq("start_ready_idle", start_ready, 1'b1);
    @(negedge clk);
    start_valid = 1'b0; data_ptr = 8'($urandom); data_size = 8'($urandom); axi_offset = $urandom;
    #2;
    check_eq("start_ready_busy", start_ready, 1'b0);
    if (size == 0) check_eq("done_zero_latency", done_valid, 1'b1);
    cyc = 0;
    while (!done_valid && cyc < 4000) begin
      @(negedge clk); #2; cyc++;
    end
    check_eq("done_timeout", done_valid, 1'b1);
    check_eq("done_err", done_err, exp_err);
    for (int k = 0; k < done_delay; k++) begin
      @(negedge clk); #2;
      check_eq("done_hold", {done_valid, done_err}, {1'b1, exp_err});
    end
    @(negedge clk); done_ready = 1'b1; #2;
    @(negedge clk); done_ready = 1'b0; #2;
    check_eq("done_release", {done_valid, start_ready}, {1'b0, 1'b1});
    check_eq("ar_all_issued", exp_ar.size(), 0);
    if (size == 0) check_eq("ar_none_for_zero", ar_seen - seen0, 0);
    nbad = 0;
    for (int i = 0; i < 256; i++) if (tb_buf[i] !== exp_buf[i]) nbad++;
    check_eq("buffer_image", nbad, 0);
    exp_ar.delete();
  endtask

  initial begin
    int nbad;
    for (int i = 0; i < 4096; i++) mem[i] = $urandom;
    for (int i = 0; i < 256; i++) begin tb_buf[i] = 32'd0; exp_buf[i] = 32'd0; end
    mem[0] = 32'hDEADBEEF;
    reset_n = 1'b0; start_valid = 1'b0; done_ready = 1'b0;
    data_ptr = 8'd0; data_size = 8'd0; axi_offset = 32'd0;
    repeat (3) @(negedge clk);
    #2;
    check_eq("reset_state",
             {start_ready, done_valid, done_err, arvalid, rready, buffer_ce, buffer_we,
              araddr, arlen, buffer_addr},
             {1'b1, 6'd0, 32'd0, 8'd0, 8'd0});
    reset_n = 1'b1;

    run_xfer(0, 1, 0, 0, 0, -1);
    check_eq("single_word", tb_buf[0], 32'hDEADBEEF);
    run_xfer(8'h10, 40, 32'h100, 0, 1, -1);
    run_xfer(8'h40, 4, 32'hFF8, 0, 0, -1);
    run_xfer(8'hFE, 4, 32'h200, 0, 0, -1);
    run_xfer(8'h60, 8, 32'h400, 0, 0, 2);
    run_xfer(8'h70, 0, 32'h500, 0, 2, -1);
    run_xfer(8'h20, 100, 32'h1F00, 0, 0, -1);
    for (int i = 0; i < 256; i++) snap[i] = tb_buf[i];
    run_xfer(8'h90, 100, 32'h1F00, 30, 5, -1);
    nbad = 0;
    for (int i = 0; i < 100; i++) if (tb_buf[8'h90 + i] !== snap[8'h20 + i]) nbad++;
    check_eq("stall_vs_nostall", nbad, 0);
    for (int t = 0; t < 6; t++)
      run_xfer($urandom_range(255), $urandom_range(60, 1), $urandom_range(32'h2FFF),
               30, $urandom_range(3), (t % 2 == 1) ? $urandom_range(20) : -1);

    // Abort a burst mid-R with reset
    stall_pct = 0; err_beat = -1;
    plan(8'h30, 40, 32'h800);
    @(negedge clk);
    start_valid = 1'b1; data_ptr = 8'h30; data_size = 8'd40; axi_offset = 32'h800;
    @(negedge clk);
    start_valid = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk); #2;
      if (rready && global_beat >= 3) break;
    end
    check_eq("reached_r_phase", rready, 1'b1);
    @(negedge clk); reset_n = 1'b0;
    @(negedge clk); #2;
    check_eq("reset_mid_r",
             {start_ready, done_valid, done_err, arvalid, rready, buffer_ce, buffer_we,
              araddr, arlen, buffer_addr, buffer_data},
             {1'b1, 6'd0, 32'd0, 8'd0, 8'd0, 32'd0});
    reset_n = 1'b1;
    exp_ar.delete();
    for (int i = 0; i < 256; i++) exp_buf[i] = tb_buf[i];
    run_xfer(8'h05, 20, 32'hC0, 30, 1, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
